// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot/run sequencer.
// Status bit order matches the host status register.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } boot_state_t;

  localparam int ADDR_SHIFT = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_W       = 3;

  function automatic logic [31:0] word_to_byte(
    input logic [31:0] w
  );
    return w << ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/mips_boot_seq_cnt.sv
// Load word counter: latches a clamped word count and
// walks the word index, flagging the final word.
module boot_load_cnt #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic [AW:0]   cnt_in,
  output logic [AW-1:0] idx,
  output logic          last
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW:0] cnt;
  logic [AW:0] pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      pos <= '0;
    end else if (load) begin
      cnt <= (cnt_in > DEPTH) ? DEPTH : cnt_in;
      pos <= '0;
    end else if (inc) begin
      pos <= pos + 1'b1;
    end
  end

  assign idx  = pos[AW-1:0];
  assign last = ((pos + 1'b1) == cnt);

endmodule

// File: rtl/mips_boot_seq.sv
// Boot and run sequencer: streams imem/dmem images, then
// runs or single-steps the core until halt, watchdog or abort.
module mips_boot_seq
  import mips_boot_pkg::*;
#(
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10,
  parameter int DATA_W  = 32,
  parameter int CYC_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [IMEM_AW:0]   n_instr,
  input  logic [DMEM_AW:0]   n_data,
  input  logic [CYC_W-1:0]   max_cycles,
  input  logic               step_mode,
  input  logic               step_req,
  input  logic               ld_valid,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               ld_ready,
  output logic               imem_we,
  output logic [31:0]        imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               dmem_we,
  output logic [31:0]        dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               core_run,
  input  logic               core_halt,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYC_W-1:0]   cycles
);

  boot_state_t state, nxt;

  logic [CYC_W-1:0]   max_r;
  logic [CYC_W-1:0]   cyc_nxt;
  logic               step_r;
  logic               step_pulse;
  logic               d_pend;
  logic               idle_like;
  logic               start_ok;
  logic               hs, hs_i, hs_d;
  logic               i_last, d_last;
  logic [IMEM_AW-1:0] i_idx;
  logic [DMEM_AW-1:0] d_idx;

  assign idle_like = (state == S_IDLE) ||
                     (state == S_DONE) ||
                     (state == S_TIMEOUT);
  assign start_ok  = start && !abort && idle_like;

  assign ld_ready = (state == S_LOAD_I) ||
                    (state == S_LOAD_D);
  assign hs   = ld_valid && ld_ready;
  assign hs_i = hs && (state == S_LOAD_I);
  assign hs_d = hs && (state == S_LOAD_D);

  assign core_run = (state == S_RUN) &&
                    (!step_r || step_pulse);
  assign cyc_nxt  = (&cycles) ? cycles : cycles + 1'b1;

  assign busy    = ld_ready || (state == S_RUN);
  assign done    = (state == S_DONE);
  assign timeout = (state == S_TIMEOUT);

  boot_load_cnt #(.AW(IMEM_AW)) u_icnt (
    .clk    (clk),
    .rst    (rst),
    .load   (start_ok),
    .inc    (hs_i),
    .cnt_in (n_instr),
    .idx    (i_idx),
    .last   (i_last)
  );

  boot_load_cnt #(.AW(DMEM_AW)) u_dcnt (
    .clk    (clk),
    .rst    (rst),
    .load   (start_ok),
    .inc    (hs_d),
    .cnt_in (n_data),
    .idx    (d_idx),
    .last   (d_last)
  );

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            if (n_instr != '0)     nxt = S_LOAD_I;
            else if (n_data != '0) nxt = S_LOAD_D;
            else                   nxt = S_RUN;
          end
        end
        S_LOAD_I: begin
          if (hs && i_last)
            nxt = d_pend ? S_LOAD_D : S_RUN;
        end
        S_LOAD_D: begin
          if (hs && d_last) nxt = S_RUN;
        end
        S_RUN: begin
          // halt outranks a watchdog hit in the same cycle
          if (core_halt)
            nxt = S_DONE;
          else if (max_r != '0 && core_run &&
                   cyc_nxt == max_r)
            nxt = S_TIMEOUT;
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      max_r      <= '0;
      step_r     <= 1'b0;
      d_pend     <= 1'b0;
      step_pulse <= 1'b0;
      cycles     <= '0;
    end else begin
      state <= nxt;
      if (start_ok) begin
        max_r  <= max_cycles;
        step_r <= step_mode;
        d_pend <= (n_data != '0);
      end
      // a request while the granted cycle is live is dropped
      step_pulse <= (state == S_RUN) && (nxt == S_RUN) &&
                    step_r && step_req && !step_pulse;
      if (start_ok)
        cycles <= '0;
      else if (core_run && !abort)
        cycles <= cyc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      imem_we <= hs_i && !abort;
      dmem_we <= hs_d && !abort;
      if (hs_i) begin
        imem_addr  <= word_to_byte(32'(i_idx));
        imem_wdata <= ld_data;
      end
      if (hs_d) begin
        dmem_addr  <= word_to_byte(32'(d_idx));
        dmem_wdata <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mips_boot_seq.sv
// Directed self-checking bench for mips_boot_seq.
module tb_mips_boot_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] n_instr = '0;
  logic [10:0] n_data = '0;
  logic [31:0] max_cycles = '0;
  logic        step_mode = 1'b0;
  logic        step_req = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        imem_we, dmem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        core_run;
  logic        core_halt = 1'b0;
  logic        busy, done, timeout;
  logic [31:0] cycles;

  int checks = 0;
  int failures = 0;

  logic [63:0] iq[$];
  logic [63:0] dq[$];
  logic        prev_run = 1'b0;
  int          b2b = 0;

  mips_boot_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .n_instr    (n_instr),
    .n_data     (n_data),
    .max_cycles (max_cycles),
    .step_mode  (step_mode),
    .step_req   (step_req),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .core_run   (core_run),
    .core_halt  (core_halt),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) iq.push_back({imem_addr, imem_wdata});
    if (dmem_we) dq.push_back({dmem_addr, dmem_wdata});
    if (core_run && prev_run) b2b++;
    prev_run <= core_run;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boot(input int ni, input int nd,
                      input int mc, input logic sm);
    n_instr    = 11'(ni);
    n_data     = 11'(nd);
    max_cycles = 32'(mc);
    step_mode  = sm;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  int acc;
  int ib, db, bb;
  logic hs;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", ld_ready, 0);
    chk("rst_run", core_run, 0);
    chk("rst_status", {busy, done, timeout}, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_we", {imem_we, dmem_we}, 0);

    // 4 instructions, valid held high
    ld_valid = 1'b1;
    boot(4, 0, 0, 0);
    chk("t1_ready", ld_ready, 1);
    for (int k = 0; k < 4; k++) begin
      ld_data = 32'hA0 + 32'(k);
      chk("t1_norun", core_run, 0);
      tick();
      chk("t1_we", imem_we, 1);
      chk("t1_addr", imem_addr, 32'(k * 4));
      chk("t1_wdata", imem_wdata, 32'hA0 + 32'(k));
    end
    chk("t1_run", core_run, 1);
    chk("t1_ready_off", ld_ready, 0);
    ld_valid = 1'b0;
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_run_off", core_run, 0);
    chk("t1_cycles", cycles, 1);

    // 2 instr + 3 data, valid toggling
    ib = iq.size();
    db = dq.size();
    acc = 0;
    boot(2, 3, 0, 0);
    for (int c = 0; c < 40 && !core_run; c++) begin
      ld_valid = (c % 2 == 0);
      ld_data = 32'hB0 + 32'(acc);
      hs = ld_valid && ld_ready;
      tick();
      if (hs) acc++;
    end
    ld_valid = 1'b0;
    chk("t2_hs", acc, 5);
    chk("t2_run", core_run, 1);
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    chk("t2_icount", iq.size() - ib, 2);
    chk("t2_dcount", dq.size() - db, 3);
    chk("t2_i0", iq[ib], {32'h0, 32'hB0});
    chk("t2_i1", iq[ib+1], {32'h4, 32'hB1});
    chk("t2_d0", dq[db], {32'h0, 32'hB2});
    chk("t2_d1", dq[db+1], {32'h4, 32'hB3});
    chk("t2_d2", dq[db+2], {32'h8, 32'hB4});

    // empty image, halt in 7th run cycle
    boot(0, 0, 0, 0);
    chk("t3_busy", busy, 1);
    for (int i = 1; i <= 7; i++) begin
      core_halt = (i == 7);
      chk("t3_run", core_run, 1);
      tick();
    end
    core_halt = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_cycles", cycles, 7);
    chk("t3_run_off", core_run, 0);

    // watchdog
    boot(0, 0, 5, 0);
    for (int i = 1; i <= 5; i++) tick();
    chk("t4_timeout", timeout, 1);
    chk("t4_done", done, 0);
    chk("t4_cycles", cycles, 5);
    chk("t4_run_off", core_run, 0);
    tick();
    tick();
    chk("t4_frozen", cycles, 5);
    boot(0, 0, 5, 0);
    for (int i = 1; i <= 5; i++) begin
      core_halt = (i == 5);
      tick();
    end
    core_halt = 1'b0;
    chk("t4h_done", done, 1);
    chk("t4h_timeout", timeout, 0);
    chk("t4h_cycles", cycles, 5);

    // single-step: 3 pulses, last back-to-back
    bb = b2b;
    boot(0, 0, 0, 1);
    chk("t5_idle_run", core_run, 0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("t5_step1", core_run, 1);
    tick();
    chk("t5_gap", core_run, 0);
    step_req = 1'b1;
    tick();
    chk("t5_step2", core_run, 1);
    tick();
    step_req = 1'b0;
    chk("t5_drop", core_run, 0);
    tick();
    tick();
    chk("t5_cycles", cycles, 2);
    chk("t5_b2b", b2b - bb, 0);
    chk("t5_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort", {busy, core_run}, 0);
    chk("t5_hold", cycles, 2);

    // abort in LOAD_D
    ld_valid = 1'b1;
    ld_data = 32'hD0;
    boot(1, 3, 0, 0);
    tick();
    chk("t6_lod", {busy, ld_ready}, 2'b11);
    ld_data = 32'hD1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ld_valid = 1'b0;
    chk("t6_ab_status", {busy, done, timeout}, 0);
    chk("t6_ab_en", {ld_ready, core_run, imem_we, dmem_we}, 0);

    db = dq.size();
    ld_valid = 1'b1;
    ld_data = 32'hC0;
    boot(0, 2, 0, 0);
    tick();
    ld_data = 32'hC1;
    tick();
    ld_valid = 1'b0;
    chk("t6_run", core_run, 1);
    tick();
    chk("t6_dcount", dq.size() - db, 2);
    chk("t6_d0", dq[db], {32'h0, 32'hC0});
    chk("t6_d1", dq[db+1], {32'h4, 32'hC1});

    // reset during RUN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_status", {busy, done, timeout}, 0);
    chk("t6_rst_en", {ld_ready, core_run, dmem_we}, 0);
    chk("t6_rst_cyc", cycles, 0);

    ib = iq.size();
    ld_valid = 1'b1;
    ld_data = 32'hE0;
    boot(2, 0, 0, 0);
    tick();
    ld_data = 32'hE1;
    tick();
    ld_valid = 1'b0;
    chk("t6r_run", core_run, 1);
    tick();
    chk("t6r_icount", iq.size() - ib, 2);
    chk("t6r_i0", iq[ib], {32'h0, 32'hE0});
    chk("t6r_i1", iq[ib+1], {32'h4, 32'hE1});
    abort = 1'b1;
    tick();
    abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_boot_seq.md
# mips_boot_seq

Parametrised boot and run sequencer for the MIPS core wrappers. It streams a program image into instruction memory and an optional initial image into data memory over one valid/ready load port. It then enables the core, either free-running or single-stepped, until the core halts, a cycle watchdog expires, or software aborts. It sits between the host load interface and `mips_core`/`ram_instr`/`ram_data`, replacing the fixed IDLE/LOAD/RUN controller in the CPU top.

## Interface
- `IMEM_AW`, 10: instruction memory word-address width; max program = 2^IMEM_AW words.
- `DMEM_AW`, 10: data memory word-address width.
- `DATA_W`, 32: load-stream and memory word width.
- `CYC_W`, 32: run-cycle counter width.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a boot sequence; honoured only in IDLE, DONE or TIMEOUT.
- `abort` in 1: forces IDLE on the next edge from any state.
- `n_instr` in IMEM_AW+1: instruction words to load; sampled on `start`.
- `n_data` in DMEM_AW+1: data words to load after instructions; sampled on `start`.
- `max_cycles` in CYC_W: watchdog limit; 0 disables; sampled on `start`.
- `step_mode` in 1: 1 = single-step; sampled on `start`.
- `step_req` in 1: pulse; grants one core cycle in step mode.
- `ld_valid` in 1, `ld_data` in DATA_W, `ld_ready` out 1: load stream.
- `imem_we` out 1, `imem_addr` out 32 (byte address), `imem_wdata` out DATA_W.
- `dmem_we` out 1, `dmem_addr` out 32 (byte address), `dmem_wdata` out DATA_W.
- `core_run` out 1: core clock-enable.
- `core_halt` in 1: core halt indication.
- `busy` out 1, `done` out 1, `timeout` out 1: status.
- `cycles` out CYC_W: core cycles executed in the current/last run.

## Operation
- States: IDLE, LOAD_I, LOAD_D, RUN, DONE, TIMEOUT.
- IDLE + `start`:
  - `n_instr`≠0 → LOAD_I.
  - else `n_data`≠0 → LOAD_D.
  - else → RUN.
- `start` in DONE/TIMEOUT behaves as in IDLE. `start` in LOAD_I, LOAD_D or RUN is ignored.
- LOAD_I:
  - `ld_ready`=1.
  - Each handshake (`ld_valid`&`ld_ready`) writes word k to byte address k<<2, with k counting from 0.
  - After word `n_instr`-1 is accepted → LOAD_D if `n_data`≠0, else RUN.
- LOAD_D: same as LOAD_I, targeting dmem, k restarting at 0. After the last word → RUN.
- Words beyond the count are never accepted, because `ld_ready` drops in the same edge as the state change.
- RUN, free mode: `core_run`=1 every cycle.
- RUN, step mode: `core_run`=1 for exactly one cycle per `step_req` pulse. `step_req` while `core_run` is already 1 is dropped, not queued.
- `cycles` is cleared on `start` and incremented on every cycle with `core_run`=1; it saturates at all-ones.
- `core_halt`=1 in RUN → DONE. `core_run` is deasserted from the next cycle.
- `max_cycles`≠0 and `cycles` reaching `max_cycles` without halt → TIMEOUT. If halt and the limit coincide in the same cycle, halt wins (DONE).
- `core_halt` outside RUN is ignored.
- DONE/TIMEOUT: `done`/`timeout` held high, `cycles` frozen, until `start`, `abort` or `rst`.
- `abort`: next state IDLE. All enables and status clear; `cycles` holds its value. `abort` beats a simultaneous `start`.
- `busy` = state ∈ {LOAD_I, LOAD_D, RUN}.
- Counts wider than memory depth: `n_instr` > 2^IMEM_AW is clamped to 2^IMEM_AW; same rule for `n_data`.

## Timing
- Reset values: every output is 0, state = IDLE, counters = 0.
- `start` at edge t: first `ld_ready`=1 in cycle t+1.
- Memory write ports are registered. A handshake at edge t gives `*_we`/addr/wdata valid for exactly the cycle after t, and the write commits at edge t+1.
- Last load handshake at edge t: `core_run`=1 in cycle t+1 when entering RUN. The final memory write commits at edge t+1, so no core fetch is issued before it.
- `core_halt` sampled high at edge t: `core_run`=0 and `done`=1 from cycle t+1.
- Step mode: `step_req` at edge t gives `core_run`=1 during cycle t+1 only.
- `rst` mid-load or mid-run: IDLE next edge; partially written memories are left as is.

## Structure
- Shared package `mips_boot_pkg` holds:
  - `boot_state_t` enum;
  - the byte-address shift constant (2);
  - the status bit ordering reused by the host status register.
- One natural sub-module, `boot_load_cnt`: parametrised word counter with load, clamp and terminal-count flag. It is instantiated twice, once per memory.
- Run/step/watchdog logic stays in the top.

## Test plan
- `n_instr`=4, `n_data`=0, `ld_valid` held high, data 0xA0..0xA3 → imem writes at byte addresses 0x0,0x4,0x8,0xC, then `core_run`=1 exactly one cycle after the last handshake.
- `n_instr`=2, `n_data`=3, `ld_valid` toggling every other cycle → only handshake cycles write; dmem addresses 0x0,0x4,0x8; no word is lost or duplicated.
- `n_instr`=`n_data`=0 → RUN is entered the cycle after `start`. Halt after 7 cycles → `done`=1, `cycles`=7.
- `max_cycles`=5 with no halt → `timeout`=1 and `cycles`=5. With `core_halt` also asserted in cycle 5 → `done`=1 and `timeout`=0.
- Step mode: 3 `step_req` pulses, one of them back-to-back with the previous → `cycles`=2, and `core_run` is never high for 2 consecutive cycles.
- `abort` during LOAD_D and `rst` during RUN → state IDLE next edge, all enables and status 0. A fresh `start` then reloads correctly.
